// File: rtl/key_conditioner_pkg.sv
// key_conditioner_pkg
//   Shared definitions for the key conditioner: the per-lane debounce state
//   encoding and the derivation of the 1 ms tick divider from the clock rate.
package key_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } lane_state_t;

    // Clock cycles per 1 ms tick.
    function automatic int tick_div(input int clk_hz);
        return clk_hz / 1000;
    endfunction

endpackage

// File: rtl/key_conditioner_lane.sv
// key_conditioner_lane
//   One key lane: two-flop synchronizer, debounce FSM, debounce counter,
//   long-press timer and registered level/event outputs.
//   Ports:
//     clk, rst_n     - system clock, asynchronous active-low reset
//     key            - raw active-low button, asynchronous to clk
//     tick           - shared 1 ms strobe from the prescaler
//     pressed        - debounced level, 1 = held
//     press_pulse    - one-cycle strobe on accepted press
//     release_pulse  - one-cycle strobe on accepted release
//     long_pulse     - one-cycle strobe once per press after the long hold
module key_conditioner_lane
    import key_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_MS = 10,
    parameter int LONG_MS     = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    input  logic tick,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int DB_W   = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
    localparam int LONG_W = (LONG_MS > 1) ? $clog2(LONG_MS) : 1;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_MS - 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_MS - 1);

    logic              sync_p0, sync_p1;
    logic              raw_p;
    lane_state_t       state, state_nxt;
    logic [DB_W-1:0]   db_cnt, db_cnt_nxt;
    logic [LONG_W-1:0] long_cnt, long_cnt_nxt;
    logic              long_done, long_done_nxt;
    logic              pressed_nxt, press_nxt, release_nxt, long_nxt;

    // Synchronizer stage: flops idle at 1 so reset looks like "released".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= key;
            sync_p1 <= sync_p0;
        end
    end

    assign raw_p = ~sync_p1;

    // FSM / counter / output register stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            db_cnt        <= '0;
            long_cnt      <= '0;
            long_done     <= 1'b0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
        end else begin
            state         <= state_nxt;
            db_cnt        <= db_cnt_nxt;
            long_cnt      <= long_cnt_nxt;
            long_done     <= long_done_nxt;
            pressed       <= pressed_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
            long_pulse    <= long_nxt;
        end
    end

    // A change of raw_p is tested before tick in every state, so a level
    // change always wins over a coincident tick.
    always_comb begin
        state_nxt     = state;
        db_cnt_nxt    = db_cnt;
        long_cnt_nxt  = long_cnt;
        long_done_nxt = long_done;
        pressed_nxt   = pressed;
        press_nxt     = 1'b0;
        release_nxt   = 1'b0;
        long_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (raw_p) begin
                    state_nxt  = PRESS_WAIT;
                    db_cnt_nxt = '0;
                end
            end
            PRESS_WAIT: begin
                if (!raw_p) begin
                    state_nxt = IDLE;
                end else if (tick) begin
                    if (db_cnt == DB_LAST) begin
                        state_nxt     = HELD;
                        press_nxt     = 1'b1;
                        pressed_nxt   = 1'b1;
                        long_cnt_nxt  = '0;
                        long_done_nxt = 1'b0;
                    end else begin
                        db_cnt_nxt = db_cnt + DB_W'(1);
                    end
                end
            end
            HELD: begin
                if (!raw_p) begin
                    state_nxt  = RELEASE_WAIT;
                    db_cnt_nxt = '0;
                end else if (tick && !long_done) begin
                    // long_done freezes long_cnt so it never wraps.
                    if (long_cnt == LONG_LAST) begin
                        long_nxt      = 1'b1;
                        long_done_nxt = 1'b1;
                    end else begin
                        long_cnt_nxt = long_cnt + LONG_W'(1);
                    end
                end
            end
            RELEASE_WAIT: begin
                // A bounce back to pressed resumes the long timer where it was.
                if (raw_p) begin
                    state_nxt = HELD;
                end else if (tick) begin
                    if (db_cnt == DB_LAST) begin
                        state_nxt   = IDLE;
                        release_nxt = 1'b1;
                        pressed_nxt = 1'b0;
                    end else begin
                        db_cnt_nxt = db_cnt + DB_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner
//   Push-button front end: a shared 1 ms prescaler feeding N_KEYS independent
//   debounce lanes.
//   Ports:
//     clk, rst_n     - system clock, asynchronous active-low reset
//     KEY            - raw active-low buttons, asynchronous to clk
//     pressed        - debounced level per key, 1 = held
//     press_pulse    - one-cycle strobe per key on accepted press
//     release_pulse  - one-cycle strobe per key on accepted release
//     long_pulse     - one-cycle strobe per key after LONG_MS of hold
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int N_KEYS      = 2,
    parameter int CLK_HZ      = 50_000_000,
    parameter int DEBOUNCE_MS = 10,
    parameter int LONG_MS     = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] KEY,
    output logic [N_KEYS-1:0] pressed,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] long_pulse
);

    localparam int TICK_DIV = tick_div(CLK_HZ);
    localparam int PRE_W    = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre_cnt;
    logic             tick;

    assign tick = (pre_cnt == PRE_MAX);

    // Prescaler stage: wraps to 0 in the cycle after the tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
        end
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_lane
        key_conditioner_lane #(
            .DEBOUNCE_MS (DEBOUNCE_MS),
            .LONG_MS     (LONG_MS)
        ) u_lane (
            .clk           (clk),
            .rst_n         (rst_n),
            .key           (KEY[i]),
            .tick          (tick),
            .pressed       (pressed[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .long_pulse    (long_pulse[i])
        );
    end

endmodule
